// File: rtl/multicycle_core_if.sv
// Unified instruction/data memory port of multicycle_core (req/ready handshake).
interface multicycle_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core sharing one ALU and one memory port across cycles.
// Define EXT_ISA_EN to add bne, ori and nor; otherwise those encodings are illegal.
module multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_core_if.master mem,
  output logic [31:0]       pc,
  output logic              instr_retire,
  output logic              illegal_op
);
  localparam int AW = $clog2(NREGS);

  localparam logic [3:0] S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR  = 4'd2,
                         S_MEMRD   = 4'd3,  S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,
                         S_RTYPEEX = 4'd6,  S_RTYPEWB = 4'd7,  S_ADDIEX  = 4'd8,
                         S_ADDIWB  = 4'd9,  S_BEQEX   = 4'd10, S_JEX     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI  = 6'h08, OP_ORI = 6'h0D, OP_LW  = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                         F_OR  = 6'h25, F_NOR = 6'h27, F_SLT = 6'h2A;

`ifdef EXT_ISA_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic [3:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;
  logic [31:0] rf_q [NREGS];

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [31:0]   rf_wdata;
  logic          req_c, we_c, retire_c, illegal_c, legal;
  logic [31:0]   addr_c;

  logic [5:0]    opcode, funct;
  logic [AW-1:0] rs_idx, rt_idx, rd_idx;
  logic [31:0]   imm_sext, imm_zext, rf_rs, rf_rt;
  logic          rtype_ok, beq_take;
  logic [31:0]   rtype_res;

  assign opcode   = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign rs_idx   = ir_q[21 +: AW];
  assign rt_idx   = ir_q[16 +: AW];
  assign rd_idx   = ir_q[11 +: AW];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_zext = {16'h0000, ir_q[15:0]};
  assign rf_rs    = (rs_idx == '0) ? 32'h0 : rf_q[rs_idx];
  assign rf_rt    = (rt_idx == '0) ? 32'h0 : rf_q[rt_idx];
  assign beq_take = (a_q == b_q) ^ (EXT && (opcode == OP_BNE));

  always_comb begin
    rtype_ok  = 1'b1;
    rtype_res = 32'h0;
    case (funct)
      F_ADD:   rtype_res = a_q + b_q;
      F_SUB:   rtype_res = a_q - b_q;
      F_AND:   rtype_res = a_q & b_q;
      F_OR:    rtype_res = a_q | b_q;
      F_SLT:   rtype_res = {31'd0, $signed(a_q) < $signed(b_q)};
      F_NOR: begin
        if (EXT) rtype_res = ~(a_q | b_q);
        else     rtype_ok  = 1'b0;
      end
      default: rtype_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    rf_we     = 1'b0;
    rf_waddr  = rt_idx;
    rf_wdata  = alu_out_q;
    req_c     = 1'b0;
    we_c      = 1'b0;
    addr_c    = pc_q;
    retire_c  = 1'b0;
    illegal_c = 1'b0;
    legal     = 1'b1;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_d    = mem.mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d       = rf_rs;
        b_d       = rf_rt;
        alu_out_d = pc_q + {imm_sext[29:0], 2'b00};
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          OP_BNE:       if (EXT) state_d = S_BEQEX;  else legal = 1'b0;
          OP_ORI:       if (EXT) state_d = S_ADDIEX; else legal = 1'b0;
          default:      legal = 1'b0;
        endcase
        // Unsupported opcode retires here as a NOP; pc already holds pc+4.
        if (!legal) begin
          state_d   = S_FETCH;
          retire_c  = 1'b1;
          illegal_c = 1'b1;
        end
      end
      S_MEMADR: begin
        alu_out_d = a_q + imm_sext;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        req_c  = 1'b1;
        addr_c = alu_out_q;
        if (mem.mem_ready) begin
          mdr_d   = mem.mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        req_c  = 1'b1;
        we_c   = 1'b1;
        addr_c = alu_out_q;
        if (mem.mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_RTYPEEX: begin
        alu_out_d = rtype_res;
        state_d   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        rf_we     = rtype_ok;
        rf_waddr  = rd_idx;
        illegal_c = !rtype_ok;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_out_d = (opcode == OP_ORI) ? (a_q | imm_zext) : (a_q + imm_sext);
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we    = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQEX: begin
        if (beq_take) pc_d = alu_out_q;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_JEX: begin
        pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      mdr_q     <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      alu_out_q <= 32'h0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      if (rf_we && (rf_waddr != '0)) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Reset is synchronous, so the outputs are gated to stay quiet while it is held.
  assign mem.mem_req   = req_c && !reset;
  assign mem.mem_we    = we_c;
  assign mem.mem_addr  = addr_c;
  assign mem.mem_wdata = b_q;
  assign pc            = pc_q;
  assign instr_retire  = retire_c && !reset;
  assign illegal_op    = illegal_c && !reset;
endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: memory model with wait states, expected
// memory transactions and retire latencies queued at load time, popped on DUT activity.
module tb_multicycle_core;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
`ifdef EXT_ISA_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                         OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                         F_NOR = 6'h27, F_SLT = 6'h2A;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  typedef struct packed {
    logic [15:0] lat;
    logic        ill;
  } ret_t;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        instr_retire;
  logic        illegal_op;

  multicycle_core_if m ();

  multicycle_core #(.RESET_PC(RESET_PC), .NREGS(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem          (m),
    .pc           (pc),
    .instr_retire (instr_retire),
    .illegal_op   (illegal_op)
  );

  logic [31:0] mem [1024];
  mem_txn_t    exp_q [$];
  ret_t        ret_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          wait_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[11:2]] = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  task automatic exp_f(input logic [31:0] a);
    exp_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
  endtask

  task automatic exp_r(input logic [31:0] a);
    exp_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
  endtask

  task automatic exp_w(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{we: 1'b1, addr: a, data: d});
  endtask

  task automatic exp_ret(input int lat, input logic ill);
    ret_q.push_back('{lat: 16'(lat), ill: ill});
  endtask

  // Memory responder: ready after wait_cyc stall cycles, scoreboard on acceptance.
  initial begin
    int       cnt;
    bit       pend;
    logic     p_we;
    logic [31:0] p_addr, p_wdata;
    mem_txn_t t;
    cnt = 0; pend = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    m.mem_ready = 1'b0;
    m.mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (m.mem_ready) begin
        m.mem_ready = 1'b0;
        cnt = 0;
      end
      if (pend && m.mem_req) begin
        chk("hold_addr", m.mem_addr, p_addr);
        chk("hold_we", m.mem_we, p_we);
        chk("hold_wdata", m.mem_wdata, p_wdata);
      end
      if (reset || !m.mem_req) cnt = 0;
      else if (cnt >= wait_cyc) begin
        m.mem_ready = 1'b1;
        m.mem_rdata = mem[m.mem_addr[11:2]];
        if (m.mem_we) mem[m.mem_addr[11:2]] = m.mem_wdata;
        if (exp_q.size() > 0) begin
          t = exp_q.pop_front();
          chk("mem_we", m.mem_we, t.we);
          chk("mem_addr", m.mem_addr, t.addr);
          if (t.we) chk("mem_wdata", m.mem_wdata, t.data);
        end
      end else cnt++;
      pend    = m.mem_req && !m.mem_ready && !reset;
      p_addr  = m.mem_addr;
      p_we    = m.mem_we;
      p_wdata = m.mem_wdata;
    end
  end

  // Retire monitor: cycles since previous retire (or since reset release).
  initial begin
    int   cyc, last;
    ret_t r;
    cyc = 0; last = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0;
        last = 0;
      end else begin
        cyc++;
        if ((instr_retire || illegal_op) && ret_q.size() > 0) begin
          r = ret_q.pop_front();
          chk("retire_lat", cyc - last, 32'(r.lat));
          chk("illegal_op", illegal_op, r.ill);
          chk("retire", instr_retire, 1'b1);
          last = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic hold_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_mem_req", m.mem_req, 1'b0);
      chk("rst_retire", instr_retire, 1'b0);
      chk("rst_illegal", illegal_op, 1'b0);
      @(posedge clk); #1;
      chk("rst_pc", pc, RESET_PC);
    end
  endtask

  task automatic release_reset();
    reset = 1'b0;
    @(negedge clk);
    chk("first_req", m.mem_req, 1'b1);
    chk("first_addr", m.mem_addr, RESET_PC);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && (exp_q.size() + ret_q.size()) != 0; i++) @(negedge clk);
    chk("drain", exp_q.size() + ret_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic load_phase_a();
    clear_mem();
    put(32'h100, enc_i(OP_ADDI, 0, 2, 16'd5));   exp_f(32'h100); exp_ret(4, 1'b0);
    put(32'h104, enc_i(OP_ADDI, 0, 3, 16'd12));  exp_f(32'h104); exp_ret(4, 1'b0);
    put(32'h108, enc_r(3, 2, 4, F_SUB));         exp_f(32'h108); exp_ret(4, 1'b0);
    put(32'h10C, enc_r(2, 3, 5, F_SLT));         exp_f(32'h10C); exp_ret(4, 1'b0);
    put(32'h110, enc_i(OP_SW, 0, 4, 16'd8));     exp_f(32'h110); exp_w(8, 7);  exp_ret(4, 1'b0);
    put(32'h114, enc_i(OP_SW, 0, 5, 16'd12));    exp_f(32'h114); exp_w(12, 1); exp_ret(4, 1'b0);
    put(32'h118, enc_i(OP_ADDI, 0, 0, 16'd9));   exp_f(32'h118); exp_ret(4, 1'b0);
    put(32'h11C, enc_r(0, 0, 7, F_ADD));         exp_f(32'h11C); exp_ret(4, 1'b0);
    put(32'h120, enc_i(OP_SW, 0, 7, 16'd16));    exp_f(32'h120); exp_w(16, 0); exp_ret(4, 1'b0);
    put(32'h124, 32'hFC00_0000);                 exp_f(32'h124); exp_ret(2, 1'b1);
    put(32'h128, enc_i(OP_BEQ, 2, 2, 16'd2));    exp_f(32'h128); exp_ret(3, 1'b0);
    put(32'h12C, enc_i(OP_ADDI, 0, 9, 16'd99));
    put(32'h130, enc_i(OP_ADDI, 0, 9, 16'd99));
    put(32'h134, enc_i(OP_BEQ, 2, 3, 16'd5));    exp_f(32'h134); exp_ret(3, 1'b0);
    put(32'h138, enc_i(OP_BNE, 2, 3, 16'd2));    exp_f(32'h138); exp_ret(EXT ? 3 : 2, !EXT);
    put(32'h13C, enc_i(OP_ADDI, 0, 9, 16'd1));
    put(32'h140, enc_i(OP_ADDI, 9, 9, 16'd2));
    if (!EXT) begin
      exp_f(32'h13C); exp_ret(4, 1'b0);
      exp_f(32'h140); exp_ret(4, 1'b0);
    end
    put(32'h144, enc_i(OP_SW, 0, 9, 16'd20));    exp_f(32'h144); exp_w(20, EXT ? 0 : 3); exp_ret(4, 1'b0);
    put(32'h148, enc_i(OP_ORI, 0, 10, 16'h8001)); exp_f(32'h148); exp_ret(EXT ? 4 : 2, !EXT);
    put(32'h14C, enc_r(0, 0, 11, F_NOR));        exp_f(32'h14C); exp_ret(4, !EXT);
    put(32'h150, enc_i(OP_SW, 0, 10, 16'd24));   exp_f(32'h150);
    exp_w(24, EXT ? 32'h0000_8001 : 32'h0);      exp_ret(4, 1'b0);
    put(32'h154, enc_i(OP_SW, 0, 11, 16'd28));   exp_f(32'h154);
    exp_w(28, EXT ? 32'hFFFF_FFFF : 32'h0);      exp_ret(4, 1'b0);
    put(32'h158, {OP_J, 26'h80});                exp_f(32'h158); exp_ret(3, 1'b0);
    put(32'h200, enc_i(OP_LW, 0, 6, 16'd8));     exp_f(32'h200); exp_r(8); exp_ret(5, 1'b0);
    put(32'h204, enc_i(OP_SW, 0, 6, 16'd32));    exp_f(32'h204); exp_w(32, 7); exp_ret(4, 1'b0);
    put(32'h208, enc_r(2, 3, 12, F_AND));        exp_f(32'h208); exp_ret(4, 1'b0);
    put(32'h20C, enc_r(2, 3, 13, F_OR));         exp_f(32'h20C); exp_ret(4, 1'b0);
    put(32'h210, enc_i(OP_SW, 0, 12, 16'd36));   exp_f(32'h210); exp_w(36, 4);  exp_ret(4, 1'b0);
    put(32'h214, enc_i(OP_SW, 0, 13, 16'd40));   exp_f(32'h214); exp_w(40, 13); exp_ret(4, 1'b0);
  endtask

  task automatic load_phase_b();
    clear_mem();
    put(32'h008, 32'hDEAD_BEEF);
    put(32'h100, enc_i(OP_ADDI, 0, 4, 16'd7));   exp_f(32'h100); exp_ret(7, 1'b0);
    put(32'h104, enc_i(OP_SW, 0, 4, 16'd8));     exp_f(32'h104); exp_w(8, 7);  exp_ret(10, 1'b0);
    put(32'h108, enc_i(OP_LW, 0, 6, 16'd8));     exp_f(32'h108); exp_r(8);     exp_ret(11, 1'b0);
    put(32'h10C, enc_i(OP_SW, 0, 6, 16'd12));    exp_f(32'h10C); exp_w(12, 7); exp_ret(10, 1'b0);
  endtask

  task automatic load_phase_c();
    clear_mem();
    put(32'h008, 32'h0000_0055);
    put(32'h100, enc_i(OP_SW, 0, 6, 16'd12));
    put(32'h104, enc_i(OP_LW, 0, 6, 16'd8));
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    @(posedge clk); #1;

    hold_reset(2);
    wait_cyc = 0;
    load_phase_a();
    release_reset();
    wait_drain();

    hold_reset(2);
    wait_cyc = 3;
    load_phase_b();
    release_reset();
    wait_drain();

    hold_reset(2);
    load_phase_c();
    exp_f(32'h100); exp_w(12, 0); exp_ret(10, 1'b0);
    exp_f(32'h104);
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (m.mem_req && !m.mem_we && m.mem_addr == 32'd8) found = 1'b1;
    end
    chk("reach_memrd", found, 1'b1);
    chk("midrst_queue", exp_q.size() + ret_q.size(), 0);
    hold_reset(2);
    exp_f(32'h100); exp_w(12, 0); exp_ret(10, 1'b0);
    release_reset();
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
